l2_burst_adaptor: RTL and testbench
===================================

# l2_burst_adaptor

Converts the L2 cache's single-transfer 256-bit line requests into 4-beat 64-bit bursts on the physical memory bus, and back. Sits directly downstream of the L2 cache: its line-side ports connect to the L2's pmem_* ports, and its burst-side ports connect to main memory. One request is in flight at a time. Line buffering and the beat counter are internal.

## Interface
- LINE_W, 256, cacheline width in bits
- BEAT_W, 64, memory bus width in bits; BEATS = LINE_W/BEAT_W = 4 (derived, must divide exactly)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low; clears all state immediately
- line_addr_i  in  32  L2 request address; low 5 bits ignored
- line_wdata_i  in  LINE_W  line to write back
- line_read_i  in  1  L2 read request, held until line_resp_o
- line_write_i  in  1  L2 write request, held until line_resp_o
- line_rdata_o  out  LINE_W  assembled read line
- line_resp_o  out  1  one-cycle completion pulse
- mem_addr_o  out  32  line-aligned burst address
- mem_wdata_o  out  BEAT_W  current write beat
- mem_read_o  out  1  burst read request
- mem_write_o  out  1  burst write request
- mem_rdata_i  in  BEAT_W  read beat data
- mem_resp_i  in  1  beat strobe; one beat transferred per cycle it is high

## Operation
- FSM states: IDLE, RD, WR, RESP.
- IDLE: if line_write_i -> capture addr (low 5 bits forced 0) and line_wdata_i, beat count = 0, go WR. Else if line_read_i -> capture addr, count = 0, go RD. Write has priority if both are high; the read is not serviced.
- RD: mem_read_o = 1. Each cycle with mem_resp_i: store mem_rdata_i into line buffer bits [BEAT_W*k +: BEAT_W], k = count, then count++. On beat 3: go RESP.
- WR: mem_write_o = 1, mem_wdata_o = buffer slice k. Advance count on mem_resp_i. On beat 3: go RESP.
- RESP: line_resp_o = 1 for exactly one cycle, then IDLE. Requests seen in RESP are ignored; the L2 drops its request the cycle after the resp.
- Beat order: beat 0 = bits [63:0] first, ascending.
- Beats need not be consecutive; cycles with mem_resp_i = 0 hold count and buffer.
- mem_resp_i in IDLE/RESP: ignored, no state change.
- line_addr_i/line_wdata_i changes after capture: ignored until next IDLE acceptance.
- line_rdata_o is driven from the line buffer. It is valid from the RESP cycle until the next request is accepted. After a write it holds the written line.
- Count is 2 bits and wraps 3->0 only via the state transition. No partial bursts are issued.

## Timing
- Reset values: line_resp_o = 0, mem_read_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_wdata_o = 0, line_rdata_o = 0, state = IDLE, count = 0.
- mem_read_o, mem_write_o and line_resp_o are decoded from registered state only, so they are glitch-free.
- Request high in IDLE at cycle 0 -> mem_read_o/mem_write_o high from cycle 1.
- Last beat at cycle N -> line_resp_o high at N+1; mem_read_o/mem_write_o low at N+1.
- Minimum latency with 4 back-to-back beats: request at cycle 0, beats at cycles 1–4, resp at cycle 5. Next request is accepted at cycle 6 at the earliest.
- Reset asserted mid-burst: return to IDLE immediately, mem_* requests drop asynchronously, the partial line is discarded, and no resp is issued. Memory must tolerate the aborted burst.

## Structure
- Shared package l2_pkg:
  - LINE_W and BEAT_W constants
  - typedef enum logic [1:0] {IDLE, RD, WR, RESP} burst_state_t
  - typedef logic [LINE_W-1:0] line_t
- Single module, no sub-modules. The line buffer is shared between read assembly and write serialization.

## Test plan
- Read, back-to-back beats: line_read_i with addr 0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 at cycles 1–4 -> mem_addr_o = 0x0000_1220, resp at cycle 5, line_rdata_o = {44..,33..,22..,11..}.
- Write with stalls: line_wdata_i = {D3,D2,D1,D0}; mem_resp_i pattern 1,0,0,1,1,0,1 -> mem_wdata_o shows D0, D1 (held 3 cycles), D2, D3 (held 2 cycles); exactly one resp after the final beat.
- Simultaneous read and write in IDLE -> only mem_write_o asserts; mem_read_o stays 0 throughout.
- Request still high in the RESP cycle -> no new burst; the following IDLE cycle with request low stays IDLE.
- Reset (rst = 0) after beat 2 of a read -> all outputs 0 within the same cycle; a fresh read afterwards completes correctly from beat 0.
- Spurious mem_resp_i in IDLE -> no state change and no resp.

Source files
------------

// File: rtl/l2_pkg.sv
// Shared constants and types for the L2 line <-> memory burst adaptor.
package l2_pkg;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int CNT_W  = $clog2(BEATS);
  // Byte offset within a line; these address bits are dropped on the memory side.
  localparam logic [31:0] LINE_ADDR_MASK = ~32'(LINE_W / 8 - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} burst_state_t;
  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BEAT_W-1:0] beat_t;
endpackage

// File: rtl/l2_burst_adaptor_if.sv
// Line-side (L2 pmem) and burst-side (main memory) signals of the adaptor.
interface l2_burst_adaptor_if;
  import l2_pkg::*;

  logic [31:0] line_addr_i;
  line_t       line_wdata_i;
  logic        line_read_i;
  logic        line_write_i;
  line_t       line_rdata_o;
  logic        line_resp_o;
  logic [31:0] mem_addr_o;
  beat_t       mem_wdata_o;
  logic        mem_read_o;
  logic        mem_write_o;
  beat_t       mem_rdata_i;
  logic        mem_resp_i;

  // slave: the adaptor itself; master: the L2 and memory surrounding it.
  modport slave (
    input  line_addr_i, line_wdata_i, line_read_i, line_write_i, mem_rdata_i, mem_resp_i,
    output line_rdata_o, line_resp_o, mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o
  );
  modport master (
    output line_addr_i, line_wdata_i, line_read_i, line_write_i, mem_rdata_i, mem_resp_i,
    input  line_rdata_o, line_resp_o, mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o
  );
endinterface

// File: rtl/l2_burst_adaptor.sv
// Splits one 256-bit L2 line transfer into a 4-beat 64-bit memory burst and back.
// A single line buffer serves both read assembly and write serialization.
module l2_burst_adaptor
  import l2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  l2_burst_adaptor_if.slave bus
);

  burst_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q;
  line_t            line_q;
  logic             rd_q, wr_q, resp_q;
  logic             last_beat;

  assign last_beat = bus.mem_resp_i && (cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      line_q <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      resp_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Write wins when both are requested; the read is left unserviced.
          if (bus.line_write_i) begin
            addr_q <= bus.line_addr_i & LINE_ADDR_MASK;
            line_q <= bus.line_wdata_i;
            cnt    <= '0;
            wr_q   <= 1'b1;
            state  <= WR;
          end else if (bus.line_read_i) begin
            addr_q <= bus.line_addr_i & LINE_ADDR_MASK;
            cnt    <= '0;
            rd_q   <= 1'b1;
            state  <= RD;
          end
        end
        RD: begin
          if (bus.mem_resp_i) begin
            line_q[BEAT_W*cnt +: BEAT_W] <= bus.mem_rdata_i;
            cnt <= cnt + 1'b1;
          end
          if (last_beat) begin
            rd_q   <= 1'b0;
            resp_q <= 1'b1;
            state  <= RESP;
          end
        end
        WR: begin
          if (bus.mem_resp_i) cnt <= cnt + 1'b1;
          if (last_beat) begin
            wr_q   <= 1'b0;
            resp_q <= 1'b1;
            state  <= RESP;
          end
        end
        RESP: begin
          resp_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_read_o   = rd_q;
  assign bus.mem_write_o  = wr_q;
  assign bus.line_resp_o  = resp_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.line_rdata_o = line_q;
  assign bus.mem_wdata_o  = wr_q ? line_q[BEAT_W*cnt +: BEAT_W] : '0;

endmodule

// File: tb/tb_l2_burst_adaptor.sv
// Randomized line-transfer bench with a transaction-level model of the burst adaptor.
module tb_l2_burst_adaptor;
  import l2_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  l2_burst_adaptor_if bus();

  l2_burst_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < LINE_W / 32; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd"},    bus.mem_read_o,   0);
    chk({tag, "_wr"},    bus.mem_write_o,  0);
    chk({tag, "_resp"},  bus.line_resp_o,  0);
    chk({tag, "_addr"},  bus.mem_addr_o,   0);
    chk({tag, "_wdata"}, bus.mem_wdata_o,  0);
    chk({tag, "_rdata"}, bus.line_rdata_o, 0);
  endtask

  // One line transfer. The model: memory sees the line as 4 beats, low slice first,
  // at the aligned address; resp follows the 4th accepted beat by one cycle, and the
  // line read back (or written) appears on line_rdata_o. plen>0 replays a fixed
  // mem_resp_i pattern (bit 0 first), otherwise each cycle strobes with pct% chance.
  task automatic xfer(input bit wr, input bit rd, input logic [31:0] addr, input line_t line,
                      input int pct, input logic [15:0] pat, input int plen, output int cyc);
    int k, p;
    bit go;
    bus.line_addr_i  = addr;
    bus.line_wdata_i = wr ? line : rand_line();
    bus.line_write_i = wr;
    bus.line_read_i  = rd;
    @(negedge clk);
    cyc = 1; k = 0; p = 0;
    // Inputs change after capture; the burst must not follow them.
    bus.line_addr_i  = $urandom;
    bus.line_wdata_i = rand_line();
    while (k < BEATS && cyc < 300) begin
      chk("mem_read",  bus.mem_read_o,  !wr);
      chk("mem_write", bus.mem_write_o, wr);
      chk("mem_addr",  bus.mem_addr_o,  addr & 32'hFFFF_FFE0);
      chk("resp_early", bus.line_resp_o, 0);
      if (wr) chk("mem_wdata", bus.mem_wdata_o, line[BEAT_W*k +: BEAT_W]);
      go = (plen > 0) ? pat[p % 16] : ($urandom_range(99) < pct);
      p++;
      bus.mem_resp_i  = go;
      bus.mem_rdata_i = go ? line[BEAT_W*k +: BEAT_W] : {$urandom, $urandom};
      if (go) k++;
      @(negedge clk);
      cyc++;
    end
    chk("beats_done", k, BEATS);
    bus.mem_resp_i = 1'b0;
    chk("resp",       bus.line_resp_o,  1);
    chk("rd_at_resp", bus.mem_read_o,   0);
    chk("wr_at_resp", bus.mem_write_o,  0);
    chk("rdata",      bus.line_rdata_o, line);
    // Request still held through the resp cycle; it must not start a new burst.
    @(negedge clk);
    bus.line_read_i  = 1'b0;
    bus.line_write_i = 1'b0;
    chk("resp_once",  bus.line_resp_o, 0);
    chk("idle_rd",    bus.mem_read_o,  0);
    chk("idle_wr",    bus.mem_write_o, 0);
    @(negedge clk);
    chk("idle2_rd",   bus.mem_read_o,  0);
    chk("idle2_wr",   bus.mem_write_o, 0);
    chk("rdata_hold", bus.line_rdata_o, line);
  endtask

  initial begin
    line_t l, d;
    int cyc;
    bus.line_addr_i  = '0;
    bus.line_wdata_i = '0;
    bus.line_read_i  = 1'b0;
    bus.line_write_i = 1'b0;
    bus.mem_rdata_i  = '0;
    bus.mem_resp_i   = 1'b0;

    #1 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Back-to-back read at a misaligned address.
    l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    xfer(1'b0, 1'b1, 32'h0000_1234, l, 100, 16'hFFFF, 16, cyc);
    chk("rd_latency", cyc, 5);

    // Write with stalls: strobe 1,0,0,1,1,0,1.
    d = rand_line();
    xfer(1'b1, 1'b0, 32'hDEAD_BEEF, d, 0, 16'h0059, 7, cyc);
    chk("wr_latency", cyc, 8);

    // Spurious strobes in IDLE change nothing.
    for (int i = 0; i < 3; i++) begin
      bus.mem_resp_i  = 1'b1;
      bus.mem_rdata_i = {$urandom, $urandom};
      @(negedge clk);
      chk("spur_resp",  bus.line_resp_o,  0);
      chk("spur_rd",    bus.mem_read_o,   0);
      chk("spur_rdata", bus.line_rdata_o, d);
    end
    bus.mem_resp_i = 1'b0;
    @(negedge clk);

    // Read and write together: only the write runs.
    d = rand_line();
    xfer(1'b1, 1'b1, 32'h0000_8040, d, 60, 16'h0, 0, cyc);

    // Reset after two beats of a read.
    l = rand_line();
    bus.line_addr_i = 32'h0000_4444;
    bus.line_read_i = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bus.mem_resp_i  = 1'b1;
      bus.mem_rdata_i = l[BEAT_W*k +: BEAT_W];
      @(negedge clk);
    end
    chk("pre_abort_rd", bus.mem_read_o, 1);
    #2 rst = 1'b0;
    #1 chk_all_zero("abort");
    @(negedge clk);
    bus.mem_resp_i  = 1'b0;
    bus.line_read_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_no_resp", bus.line_resp_o, 0);
    l = rand_line();
    xfer(1'b0, 1'b1, 32'h0000_4444, l, 100, 16'hFFFF, 16, cyc);
    chk("post_abort_lat", cyc, 5);

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      bit w, r;
      w = $urandom_range(1);
      r = w ? bit'($urandom_range(1)) : 1'b1;
      xfer(w, r, $urandom, rand_line(), $urandom_range(100, 25), 16'h0, 0, cyc);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
